// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B transmit chain.
// Default timing targets a 50 MHz system clock.
package ws2812b_pkg;

  localparam int unsigned BITS_PER_PIXEL = 24;

  localparam int unsigned DEFAULT_BIT_PERIOD   = 62;
  localparam int unsigned DEFAULT_PIXELS       = 60;
  localparam int unsigned DEFAULT_RESET_CYCLES = 2800;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StLatch
  } state_e;

  // Width needed to hold 0..terminal-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/ws2812b_interval_timer.sv
// Up-counter over 0..TERMINAL-1 with synchronous clear and a terminal-count flag.
// Wraps to zero after the terminal count while enabled.
module ws2812b_interval_timer
  import ws2812b_pkg::*;
#(
  parameter int unsigned TERMINAL = 4,
  localparam int unsigned CW = cnt_width(TERMINAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q, count_d;

  assign tc    = (count_q == CW'(TERMINAL - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame sequencer for the WS2812B FIFO transmitter: bit/word strobes, pixel
// sequencing, latch gap, and busy/done/underrun status towards the host.
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int unsigned BIT_PERIOD   = DEFAULT_BIT_PERIOD,
  parameter int unsigned PIXELS       = DEFAULT_PIXELS,
  parameter int unsigned RESET_CYCLES = DEFAULT_RESET_CYCLES,
  localparam int unsigned PW = cnt_width(PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          fifo_valid,
  input  logic          clear_underrun,
  output logic          btrig,
  output logic          wtrig,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun,
  output logic [PW-1:0] pixel_index
);

  localparam int unsigned BW  = cnt_width(BITS_PER_PIXEL);
  localparam int unsigned PCW = cnt_width(BIT_PERIOD);
  localparam int unsigned LCW = cnt_width(RESET_CYCLES);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pixel_cnt_q, pixel_cnt_d;
  logic          underrun_q, underrun_d;
  logic          set_underrun;

  logic           in_shift, in_latch, last_pixel, last_bit;
  logic [PCW-1:0] period_cnt;
  logic           period_tc;
  logic [LCW-1:0] unused_latch_cnt;
  logic           latch_tc;

  assign in_shift   = (state_q == StShift);
  assign in_latch   = (state_q == StLatch);
  assign last_pixel = (pixel_cnt_q == PW'(PIXELS - 1));
  assign last_bit   = (bit_cnt_q == BW'(BITS_PER_PIXEL - 1));

  // Held at zero outside SHIFT so the first bit of a frame starts a full period.
  ws2812b_interval_timer #(
    .TERMINAL(BIT_PERIOD)
  ) u_period_timer (
    .clk  (clk),
    .reset(reset),
    .clear(!in_shift),
    .en   (in_shift),
    .count(period_cnt),
    .tc   (period_tc)
  );

  ws2812b_interval_timer #(
    .TERMINAL(RESET_CYCLES)
  ) u_latch_timer (
    .clk  (clk),
    .reset(reset),
    .clear(!in_latch),
    .en   (in_latch),
    .count(unused_latch_cnt),
    .tc   (latch_tc)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    pixel_cnt_d  = pixel_cnt_q;
    set_underrun = 1'b0;
    wtrig        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && enable) begin
          if (fifo_valid) begin
            state_d = StLoad;
          end else begin
            set_underrun = 1'b1;
          end
        end
      end

      StLoad: begin
        wtrig       = 1'b1;
        bit_cnt_d   = '0;
        pixel_cnt_d = '0;
        state_d     = StShift;
      end

      StShift: begin
        if (!enable) begin
          state_d = StLatch;
        end else if (period_tc) begin
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (last_pixel) begin
            state_d = StLatch;
          end else if (fifo_valid) begin
            // Pop the next word in the last cycle of the pixel so bits run back to back.
            wtrig       = 1'b1;
            pixel_cnt_d = pixel_cnt_q + PW'(1);
            bit_cnt_d   = '0;
          end else begin
            set_underrun = 1'b1;
            state_d      = StLatch;
          end
        end
      end

      StLatch: begin
        if (latch_tc) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (set_underrun) begin
      underrun_d = 1'b1;
    end else if (clear_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      pixel_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pixel_cnt_q <= pixel_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  assign btrig       = in_shift && (period_cnt == '0);
  assign busy        = (state_q != StIdle);
  assign frame_done  = in_latch && latch_tc;
  assign underrun    = underrun_q;
  assign pixel_index = pixel_cnt_q;

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Scoreboard bench for ws2812b_frame_sequencer: stimulus queues expected strobe
// events, a negedge monitor pops and compares them as the DUT emits pulses.
module tb_ws2812b_frame_sequencer;

  localparam int unsigned BP = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned RC = 10;

  logic       clk = 1'b0;
  logic       reset, enable, start, fifo_valid, clear_underrun;
  logic       btrig, wtrig, busy, frame_done, underrun;
  logic [0:0] pixel_index;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];

  ws2812b_frame_sequencer #(
    .BIT_PERIOD  (BP),
    .PIXELS      (NP),
    .RESET_CYCLES(RC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .fifo_valid    (fifo_valid),
    .clear_underrun(clear_underrun),
    .btrig         (btrig),
    .wtrig         (wtrig),
    .busy          (busy),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .pixel_index   (pixel_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      0:       return "wtrig";
      1:       return "btrig";
      default: return "frame_done";
    endcase
  endfunction

  task automatic check_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", kind_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 kind_name(kind), cyc, kind_name(e.kind), e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wtrig)      check_event(0);
    if (btrig)      check_event(1);
    if (frame_done) check_event(2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, want);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Expected strobes of a frame whose start is sampled in cycle base.
  task automatic push_frame(input int base, input int nb, input bit w2, input int done_off);
    push(0, base + 1);
    for (int k = 0; k < nb; k++) begin
      if (w2 && k == 24) push(0, base + 1 + 24 * BP);
      push(1, base + 2 + BP * k);
    end
    if (done_off >= 0) push(2, base + done_off);
  endtask

  task automatic check_drained(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d pending events, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int base;
    reset          = 1'b1;
    enable         = 1'b1;
    start          = 1'b0;
    fifo_valid     = 1'b1;
    clear_underrun = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_underrun", underrun, 0);
    check("reset_btrig", btrig, 0);
    check("reset_wtrig", wtrig, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_pixel_index", pixel_index, 0);
    reset = 1'b0;
    tick();

    // Basic frame
    base  = cyc;
    start = 1'b1;
    push_frame(base, 48, 1'b1, 203);
    tick();
    start = 1'b0;
    check("basic_busy_load", busy, 1);
    wait_to(base + 50);
    check("basic_pixel0", pixel_index, 0);
    wait_to(base + 100);
    check("basic_pixel1", pixel_index, 1);
    wait_to(base + 203);
    check("basic_busy_last", busy, 1);
    wait_to(base + 204);
    check("basic_idle", busy, 0);
    check("basic_underrun", underrun, 0);
    check_drained("basic");
    tick();

    // Underrun at the pixel boundary
    base  = cyc;
    start = 1'b1;
    push_frame(base, 24, 1'b0, 107);
    tick();
    start = 1'b0;
    wait_to(base + 97);
    fifo_valid = 1'b0;
    check("ur_before", underrun, 0);
    wait_to(base + 98);
    fifo_valid = 1'b1;
    check("ur_set", underrun, 1);
    check("ur_busy_latch", busy, 1);
    wait_to(base + 108);
    check("ur_idle", busy, 0);
    wait_to(base + 110);
    clear_underrun = 1'b1;
    check("ur_sticky", underrun, 1);
    wait_to(base + 111);
    clear_underrun = 1'b0;
    check("ur_cleared", underrun, 0);
    check_drained("underrun");

    // Empty start, then set-wins against clear
    fifo_valid = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("empty_underrun", underrun, 1);
    check("empty_busy", busy, 0);
    tick();
    tick();
    check("empty_still_idle", busy, 0);
    clear_underrun = 1'b1;
    start          = 1'b1;
    tick();
    start = 1'b0;
    check("set_wins", underrun, 1);
    tick();
    check("clear_after", underrun, 0);
    clear_underrun = 1'b0;
    fifo_valid     = 1'b1;
    check_drained("empty");

    // Abort by enable
    base  = cyc;
    start = 1'b1;
    push_frame(base, 13, 1'b0, 60);
    tick();
    start = 1'b0;
    wait_to(base + 50);
    enable = 1'b0;
    wait_to(base + 51);
    enable = 1'b1;
    check("abort_busy", busy, 1);
    wait_to(base + 60);
    check("abort_busy_last", busy, 1);
    wait_to(base + 61);
    check("abort_idle", busy, 0);
    check("abort_underrun", underrun, 0);
    check_drained("abort");

    // Reset mid-frame, then a fresh frame
    base  = cyc;
    start = 1'b1;
    push_frame(base, 10, 1'b0, -1);
    tick();
    start = 1'b0;
    wait_to(base + 40);
    reset = 1'b1;
    wait_to(base + 41);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_btrig", btrig, 0);
    check("rst_wtrig", wtrig, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel_index", pixel_index, 0);
    check_drained("reset_abort");
    wait_to(base + 45);
    start = 1'b1;
    push_frame(base + 45, 48, 1'b1, 203);
    tick();
    start = 1'b0;
    wait_to(base + 45 + 204);
    check("rst_refrm_idle", busy, 0);
    check_drained("reset_refrm");

    // Start while busy is ignored
    base  = cyc;
    start = 1'b1;
    push_frame(base, 48, 1'b1, 203);
    tick();
    start = 1'b0;
    wait_to(base + 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 210);
    check("busy_start_idle", busy, 0);
    check_drained("busy_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
